// File: rtl/replica_pkg.sv
// Shared route-word types for the replica routing datapath.
// One word packs eight 8-bit city indices.
package replica_pkg;

    localparam int unsigned city_num    = 64;
    localparam int unsigned CityBits    = 8;
    localparam int unsigned ROUTE_WORDS = city_num / 8;

    typedef logic [8*CityBits-1:0] replica_data_t;

endpackage

// File: rtl/route_store_if.sv
// Route-store bus: read port, write-back stream, host load port and pass status.
interface route_store_if
    import replica_pkg::*;
#(
    parameter int unsigned AW = 3
);
    logic            start;
    logic [AW-1:0]   rd_addr;
    replica_data_t   rd_data;
    logic            in_valid;
    replica_data_t   in_data;
    logic            ld_we;
    logic [AW-1:0]   ld_addr;
    replica_data_t   ld_data;
    logic            busy;
    logic            done;
    logic            overflow;

    modport master (
        output start, rd_addr, in_valid, in_data, ld_we, ld_addr, ld_data,
        input  rd_data, busy, done, overflow
    );

    modport slave (
        input  start, rd_addr, in_valid, in_data, ld_we, ld_addr, ld_data,
        output rd_data, busy, done, overflow
    );
endinterface

// File: rtl/route_ram.sv
// Route word storage: one write port, one registered read port, read-before-write.
// Out-of-range writes are dropped and out-of-range reads return zero.
module route_ram
    import replica_pkg::*;
#(
    parameter int unsigned WORDS = ROUTE_WORDS,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  replica_data_t wr_data,
    input  logic [AW-1:0] rd_addr,
    output replica_data_t rd_data
);

    replica_data_t mem [WORDS];
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok = 32'(wr_addr) < WORDS;
    assign rd_ok = 32'(rd_addr) < WORDS;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/route_store.sv
// Route store: sequences write-back passes from the routing stage into route_ram,
// arbitrates host loads against passes and flags stray traffic as overflow.
module route_store
    import replica_pkg::*;
#(
    parameter int unsigned WORDS = ROUTE_WORDS,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         reset,
    route_store_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          overflow_q, overflow_d;

    logic [AW-1:0] pass_addr;
    logic          pass_we;
    logic          ld_ok;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    replica_data_t ram_data;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        overflow_d = overflow_q;
        pass_we    = 1'b0;
        // A start in the same cycle as a word restarts the pass at address 0.
        pass_addr  = bus.start ? '0 : wr_addr_q;
        ld_ok      = bus.ld_we && (state_q == StIdle);

        if (bus.start) begin
            state_d    = StActive;
            wr_addr_d  = '0;
            overflow_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && !bus.start) begin
                    overflow_d = 1'b1;
                end
            end
            StActive: begin
                pass_we = bus.in_valid;
            end
            StDone: begin
                pass_we = bus.in_valid && bus.start;
                if (!bus.start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.ld_we && (state_q != StIdle)) begin
            overflow_d = 1'b1;
        end

        if (pass_we) begin
            if (pass_addr == LastAddr) begin
                state_d   = StDone;
                wr_addr_d = '0;
            end else begin
                wr_addr_d = pass_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            overflow_q <= overflow_d;
        end
    end

    // Pass writes and host loads never overlap: loads are only honoured in idle.
    assign ram_we   = pass_we || ld_ok;
    assign ram_addr = pass_we ? pass_addr : bus.ld_addr;
    assign ram_data = pass_we ? bus.in_data : bus.ld_data;

    route_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (ram_we),
        .wr_addr (ram_addr),
        .wr_data (ram_data),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_route_store.sv
// Directed-sequence bench for route_store with random data words checked
// against a plain array model of the expected memory contents.
module tb_route_store;
    import replica_pkg::*;

    localparam int unsigned WORDS = 8;
    localparam int unsigned AW    = 3;

    logic clk;
    logic reset;

    route_store_if #(.AW(AW)) bus ();

    route_store #(
        .WORDS (WORDS),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int done_cnt;
    int dc0;
    replica_data_t model [WORDS];
    replica_data_t x_word;
    replica_data_t y_word;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input replica_data_t obs, input replica_data_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic replica_data_t rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic read_all(input string tag);
        for (int k = 0; k < WORDS; k++) begin
            bus.rd_addr = AW'(k);
            tick();
            check($sformatf("%s[%0d]", tag, k), bus.rd_data, model[k]);
        end
    endtask

    task automatic pass_word(input int idx);
        replica_data_t d;
        d = rnd_word();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        model[idx]   = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.rd_addr  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;

        repeat (2) tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
        check("rst_rd_data", bus.rd_data, '0);
        reset = 1'b1;
        tick();

        // Host load k*0x11, then back-to-back readback.
        for (int k = 0; k < WORDS; k++) begin
            bus.ld_we   = 1'b1;
            bus.ld_addr = AW'(k);
            bus.ld_data = replica_data_t'(k * 'h11);
            model[k]    = replica_data_t'(k * 'h11);
            tick();
        end
        bus.ld_we = 1'b0;
        read_all("load_read");
        check("load_overflow", 64'(bus.overflow), 64'(0));

        // Full pass with a one-cycle gap after word 2.
        dc0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("pass_busy", 64'(bus.busy), 64'(1));
        for (int i = 0; i < WORDS; i++) begin
            pass_word(i);
            check($sformatf("pass_done_w%0d", i), 64'(bus.done), 64'(i == WORDS - 1));
            if (i == 2) begin
                tick();
                check("pass_done_gap", 64'(bus.done), 64'(0));
            end
        end
        check("pass_busy_done", 64'(bus.busy), 64'(1));
        tick();
        check("pass_done_fall", 64'(bus.done), 64'(0));
        check("pass_busy_fall", 64'(bus.busy), 64'(0));
        check("pass_done_cnt", 64'(done_cnt - dc0), 64'(1));
        read_all("pass_mem");

        // Read-before-write on address 3.
        y_word = model[3];
        x_word = rnd_word();
        bus.ld_we   = 1'b1;
        bus.ld_addr = 3'd3;
        bus.ld_data = x_word;
        bus.rd_addr = 3'd3;
        tick();
        bus.ld_we = 1'b0;
        model[3]  = x_word;
        check("rbw_old", bus.rd_data, y_word);
        tick();
        check("rbw_new", bus.rd_data, x_word);

        // Restart after four words.
        dc0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) pass_word(i);
        check("restart_busy", 64'(bus.busy), 64'(1));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < WORDS; i++) pass_word(i);
        tick();
        check("restart_busy_end", 64'(bus.busy), 64'(0));
        check("restart_done_cnt", 64'(done_cnt - dc0), 64'(1));
        read_all("restart_mem");

        // Stray word in idle.
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_word();
        tick();
        bus.in_valid = 1'b0;
        check("ovf_idle", 64'(bus.overflow), 64'(1));
        read_all("ovf_idle_mem");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ovf_start_clr", 64'(bus.overflow), 64'(0));

        // Host load during a pass is ignored.
        bus.ld_we   = 1'b1;
        bus.ld_addr = 3'd5;
        bus.ld_data = rnd_word();
        tick();
        bus.ld_we   = 1'b0;
        check("ovf_ld_active", 64'(bus.overflow), 64'(1));
        bus.rd_addr = 3'd5;
        tick();
        check("ovf_ld_mem5", bus.rd_data, model[5]);
        for (int i = 0; i < WORDS; i++) pass_word(i);
        tick();
        check("ovf_sticky", 64'(bus.overflow), 64'(1));
        read_all("ovf_pass_mem");

        // Reset after five of eight words.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rp_ovf_clr", 64'(bus.overflow), 64'(0));
        dc0 = done_cnt;
        for (int i = 0; i < 5; i++) pass_word(i);
        bus.ld_we = 1'b1;
        tick();
        bus.ld_we = 1'b0;
        check("rp_ovf_set", 64'(bus.overflow), 64'(1));
        reset = 1'b0;
        #1;
        check("rp_busy", 64'(bus.busy), 64'(0));
        check("rp_done", 64'(bus.done), 64'(0));
        check("rp_overflow", 64'(bus.overflow), 64'(0));
        check("rp_rd_data", bus.rd_data, '0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("rp_busy_after", 64'(bus.busy), 64'(0));
        check("rp_done_cnt", 64'(done_cnt - dc0), 64'(0));
        read_all("rp_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
